// File: rtl/mm_counter_game.sv
// Four-bit multi-mode up/down counter with a win/lose scorekeeper.
// Landing on zero scores a loss and landing on all-ones scores a win; TALLY_MAX of either ends the game.
module mm_counter_game #(
    parameter int CNT_W     = 4,
    parameter int TALLY_MAX = 15
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic [1:0]       ctrl,
    input  logic [CNT_W-1:0] inval,
    input  logic             INIT,
    output logic [CNT_W-1:0] count,
    output logic             LOSER,
    output logic             WINNER,
    output logic             GAMEOVER,
    output logic [1:0]       WHO
);

    localparam int TALLY_W = $clog2(TALLY_MAX + 1);
    localparam logic [TALLY_W-1:0] TALLY_LAST = TALLY_W'(TALLY_MAX - 1);

    typedef enum logic [1:0] {
        WHO_NONE   = 2'b00,
        WHO_LOSER  = 2'b01,
        WHO_WINNER = 2'b10
    } who_t;

    typedef enum logic {
        PLAY = 1'b0,
        HOLD = 1'b1
    } phase_t;

    phase_t             phase;
    who_t               who_q;
    logic [TALLY_W-1:0] loss_tally;
    logic [TALLY_W-1:0] win_tally;
    logic [CNT_W-1:0]   stepped;

    assign LOSER    = (count == '0);
    assign WINNER   = (count == '1);
    assign GAMEOVER = (phase == HOLD);
    assign WHO      = who_q;

    // Wrap-around in either direction falls out of the fixed-width arithmetic.
    always_comb begin
        stepped = count;
        unique case (ctrl)
            2'b00:   stepped = count + CNT_W'(1);
            2'b01:   stepped = count + CNT_W'(2);
            2'b10:   stepped = count - CNT_W'(1);
            default: stepped = count - CNT_W'(2);
        endcase
    end

    always_ff @(posedge clk) begin
        if (arstn) begin
            phase      <= PLAY;
            who_q      <= WHO_NONE;
            loss_tally <= '0;
            win_tally  <= '0;
            count      <= '0;
        end else if (phase == HOLD) begin
            phase <= PLAY;
        end else if (LOSER && loss_tally == TALLY_LAST) begin
            phase      <= HOLD;
            who_q      <= WHO_LOSER;
            loss_tally <= '0;
            win_tally  <= '0;
            count      <= '0;
        end else if (WINNER && win_tally == TALLY_LAST) begin
            phase      <= HOLD;
            who_q      <= WHO_WINNER;
            loss_tally <= '0;
            win_tally  <= '0;
            count      <= '0;
        end else begin
            // Scoring uses the current count, so a value parked at 0 or F scores every cycle.
            if (LOSER)
                loss_tally <= loss_tally + TALLY_W'(1);
            if (WINNER)
                win_tally <= win_tally + TALLY_W'(1);
            count <= INIT ? inval : stepped;
        end
    end

endmodule

// File: tb/tb_mm_counter_game.sv
// Self-checking bench for mm_counter_game: directed scenarios followed by a randomized run,
// every cycle compared against a behavioural scorekeeping model.
module tb_mm_counter_game;

    logic       clk;
    logic       arstn;
    logic [1:0] ctrl;
    logic [3:0] inval;
    logic       INIT;
    logic [3:0] count;
    logic       LOSER;
    logic       WINNER;
    logic       GAMEOVER;
    logic [1:0] WHO;

    int vectors;
    int miscompares;

    // Reference model state: plain integers, updated once per rising edge.
    int  m_count;
    int  m_losses;
    int  m_wins;
    bit  m_over;
    int  m_who;

    mm_counter_game #(.CNT_W(4), .TALLY_MAX(15)) dut (
        .clk     (clk),
        .arstn   (arstn),
        .ctrl    (ctrl),
        .inval   (inval),
        .INIT    (INIT),
        .count   (count),
        .LOSER   (LOSER),
        .WINNER  (WINNER),
        .GAMEOVER(GAMEOVER),
        .WHO     (WHO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelEdge(input bit rst, input bit init, input int c, input int v);
        int steps[4] = '{1, 2, -1, -2};
        bit lose_now;
        bit win_now;
        if (rst) begin
            m_count = 0; m_losses = 0; m_wins = 0; m_over = 0; m_who = 0;
        end else if (m_over) begin
            m_over = 0;
        end else begin
            lose_now = (m_count == 0);
            win_now  = (m_count == 15);
            if (lose_now && m_losses + 1 == 15) begin
                m_over = 1; m_who = 1; m_count = 0; m_losses = 0; m_wins = 0;
            end else if (win_now && m_wins + 1 == 15) begin
                m_over = 1; m_who = 2; m_count = 0; m_losses = 0; m_wins = 0;
            end else begin
                if (lose_now) m_losses++;
                if (win_now)  m_wins++;
                m_count = init ? v : (m_count + steps[c] + 16) % 16;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        vectors++;
        assert (count === 4'(m_count)) else begin
            miscompares++;
            $error("[TB] FAIL %s count: got %0h expected %0h", tag, count, m_count);
        end
        vectors++;
        assert (LOSER === (m_count == 0)) else begin
            miscompares++;
            $error("[TB] FAIL %s LOSER: got %0b expected %0b", tag, LOSER, m_count == 0);
        end
        vectors++;
        assert (WINNER === (m_count == 15)) else begin
            miscompares++;
            $error("[TB] FAIL %s WINNER: got %0b expected %0b", tag, WINNER, m_count == 15);
        end
        vectors++;
        assert (GAMEOVER === m_over) else begin
            miscompares++;
            $error("[TB] FAIL %s GAMEOVER: got %0b expected %0b", tag, GAMEOVER, m_over);
        end
        vectors++;
        assert (WHO === 2'(m_who)) else begin
            miscompares++;
            $error("[TB] FAIL %s WHO: got %0d expected %0d", tag, WHO, m_who);
        end
    endtask

    // Direct checks against hand-derived constants, independent of the model.
    task automatic checkValue(input string tag, input int got, input int exp);
        vectors++;
        assert (got == exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit init, input int c, input int v,
                                 input string tag);
        @(negedge clk);
        arstn = rst;
        INIT  = init;
        ctrl  = 2'(c);
        inval = 4'(v);
        @(posedge clk);
        modelEdge(rst, init, c, v);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        int c;
        int v;
        bit init;
        bit rst;
        vectors = 0;
        miscompares = 0;
        arstn = 1'b1; INIT = 1'b0; ctrl = 2'b00; inval = 4'h0;
        m_count = 0; m_losses = 0; m_wins = 0; m_over = 0; m_who = 0;

        applyStimulus(1, 0, 0, 0, "reset");
        applyStimulus(1, 0, 0, 0, "reset");
        checkValue("reset count", count, 0);
        checkValue("reset LOSER", LOSER, 1);
        checkValue("reset WINNER", WINNER, 0);
        checkValue("reset GAMEOVER", GAMEOVER, 0);
        checkValue("reset WHO", WHO, 0);

        applyStimulus(0, 1, 0, 5, "load5");
        applyStimulus(0, 0, 0, 0, "plus1");
        checkValue("sweep +1", count, 6);
        applyStimulus(0, 0, 1, 0, "plus2");
        checkValue("sweep +2", count, 8);
        applyStimulus(0, 0, 2, 0, "minus1");
        checkValue("sweep -1", count, 7);
        applyStimulus(0, 0, 3, 0, "minus2");
        checkValue("sweep -2", count, 5);

        applyStimulus(0, 1, 0, 14, "loadE");
        applyStimulus(0, 0, 1, 0, "E+2");
        checkValue("wrap E+2", count, 0);
        checkValue("wrap E+2 LOSER", LOSER, 1);
        applyStimulus(0, 1, 0, 1, "load1");
        applyStimulus(0, 0, 3, 0, "1-2");
        checkValue("wrap 1-2", count, 15);
        checkValue("wrap 1-2 WINNER", WINNER, 1);
        applyStimulus(0, 1, 0, 15, "loadF");
        applyStimulus(0, 0, 0, 0, "F+1");
        checkValue("wrap F+1", count, 0);
        applyStimulus(0, 1, 1, 9, "initprio");
        checkValue("INIT priority", count, 9);

        // Loser game over twice in a row from a clean reset.
        applyStimulus(1, 0, 0, 0, "reset2");
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 14; i++) applyStimulus(0, 1, 0, 0, "loserun");
            checkValue("loser pre-end GAMEOVER", GAMEOVER, 0);
            applyStimulus(0, 1, 0, 0, "loser15");
            checkValue("loser GAMEOVER", GAMEOVER, 1);
            checkValue("loser WHO", WHO, 1);
            checkValue("loser count", count, 0);
            applyStimulus(0, 1, 2, 7, "loserhold");
            checkValue("loser hold GAMEOVER", GAMEOVER, 0);
            checkValue("loser hold count", count, 0);
            checkValue("loser hold WHO", WHO, 1);
        end

        // Winner game over, then a reset partway into the next run.
        applyStimulus(1, 0, 0, 0, "reset3");
        applyStimulus(0, 1, 0, 15, "loadFwin");
        for (int i = 0; i < 14; i++) applyStimulus(0, 1, 0, 15, "winrun");
        checkValue("winner pre-end GAMEOVER", GAMEOVER, 0);
        applyStimulus(0, 1, 0, 15, "winner15");
        checkValue("winner GAMEOVER", GAMEOVER, 1);
        checkValue("winner WHO", WHO, 2);
        applyStimulus(0, 1, 0, 15, "winnerhold");
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 15, "win7");
        applyStimulus(1, 1, 0, 15, "midreset");
        checkValue("midreset WHO", WHO, 0);
        checkValue("midreset count", count, 0);
        applyStimulus(0, 1, 0, 15, "reloadF");
        for (int i = 0; i < 14; i++) applyStimulus(0, 1, 0, 15, "winrun2");
        checkValue("fresh run pre-end GAMEOVER", GAMEOVER, 0);
        applyStimulus(0, 1, 0, 15, "winner15b");
        checkValue("fresh run GAMEOVER", GAMEOVER, 1);
        checkValue("fresh run WHO", WHO, 2);

        // Randomized run, biased towards parking the count at 0 or F so games finish.
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 79) == 0);
            init = ($urandom_range(0, 2) != 0);
            c    = int'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0, 1, 2: v = 0;
                3, 4, 5: v = 15;
                default: v = int'($urandom_range(0, 15));
            endcase
            applyStimulus(rst, init, c, v, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
